// File: rtl/addsub_pkg.sv
// Shared constants and configuration check for the pipelined adder/subtractor.
// Operation encodings plus the chunking legality test used at elaboration.
package addsub_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic bit chunks_ok(input int n, input int s);
        return (s >= 1) && (s <= n) && ((n % s) == 0);
    endfunction

endpackage

// File: rtl/addsub_chunk.sv
// W-bit ripple adder slice: one chunk of the pipelined datapath.
// Also exposes the carry into its MSB for signed-overflow detection.
module addsub_chunk #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] full;

    assign full     = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign s        = full[W-1:0];
    assign cout     = full[W];
    // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
    assign c_msb_in = a[W-1] ^ b[W-1] ^ s[W-1];

endmodule

// File: rtl/pipelined_addsub_nbit.sv
// N-bit adder/subtractor split into STAGES ripple chunks, one per pipeline stage.
// A single advance enable moves the whole pipe; earlier sum chunks ride along.
module pipelined_addsub_nbit
    import addsub_pkg::*;
#(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int W = N / STAGES;

    if (!chunks_ok(N, STAGES)) begin : g_bad_cfg
        $error("pipelined_addsub_nbit: N must be a multiple of STAGES");
    end

    logic adv;

    logic [STAGES-1:0]        vld_q, vld_d;
    logic [STAGES-1:0][N-1:0] a_q, a_d;
    logic [STAGES-1:0][N-1:0] b_q, b_d;
    logic [STAGES-1:0][N-1:0] res_q, res_d;
    logic [STAGES-1:0]        c_q, c_d;
    logic                     ovf_q, ovf_d;

    logic [STAGES-1:0][N-1:0] a_in, b_in, r_in;
    logic [STAGES-1:0]        c_in;
    logic [STAGES-1:0][W-1:0] s_ch;
    logic [STAGES-1:0]        co_ch, cm_ch;

    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign a_in[k] = a;
            assign b_in[k] = (sub == SUB) ? ~b : b;
            assign c_in[k] = sub;
            assign r_in[k] = '0;
        end else begin : g_next
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign r_in[k] = res_q[k-1];
        end

        addsub_chunk #(
            .W(W)
        ) u_chunk (
            .a       (a_in[k][k*W +: W]),
            .b       (b_in[k][k*W +: W]),
            .cin     (c_in[k]),
            .s       (s_ch[k]),
            .cout    (co_ch[k]),
            .c_msb_in(cm_ch[k])
        );
    end

    // Next state: on advance every stage takes its predecessor's outputs.
    always_comb begin
        vld_d = vld_q;
        a_d   = a_q;
        b_d   = b_q;
        res_d = res_q;
        c_d   = c_q;
        ovf_d = ovf_q;
        if (adv) begin
            vld_d = (vld_q << 1) | STAGES'(in_valid);
            a_d   = a_in;
            b_d   = b_in;
            c_d   = co_ch;
            for (int k = 0; k < STAGES; k++) begin
                res_d[k]            = r_in[k];
                res_d[k][k*W +: W]  = s_ch[k];
            end
            ovf_d = cm_ch[STAGES-1] ^ co_ch[STAGES-1];
        end
    end

    // Pipeline registers; data is cleared too so reset waveforms are clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            res_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            c_q   <= c_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign sum       = res_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Already-consumed low operand chunks and last-stage operands are dead.
    logic unused_ok;
    assign unused_ok = ^{a_q, b_q, cm_ch};

endmodule

// File: tb/tb_pipelined_addsub_nbit.sv
// Directed and randomised checks for pipelined_addsub_nbit in three shapes.
// Expected values come from hand-computed constants and a small arithmetic model.
module tb_pipelined_addsub_nbit;

    logic clk;
    logic rst;

    logic        iv0, ir0, s0, ov0, or0, co0, of0;
    logic [15:0] a0, b0, sum0;
    logic        iv1, ir1, s1, ov1, or1, co1, of1;
    logic [7:0]  a1, b1, sum1;
    logic        iv2, ir2, s2, ov2, or2, co2, of2;
    logic [31:0] a2, b2, sum2;

    int n_checks = 0;
    int n_err    = 0;

    pipelined_addsub_nbit #(.N(16), .STAGES(4)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0),
        .a(a0), .b(b0), .sub(s0), .out_valid(ov0), .out_ready(or0),
        .sum(sum0), .cout(co0), .ovf(of0)
    );

    pipelined_addsub_nbit #(.N(8), .STAGES(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1),
        .a(a1), .b(b1), .sub(s1), .out_valid(ov1), .out_ready(or1),
        .sum(sum1), .cout(co1), .ovf(of1)
    );

    pipelined_addsub_nbit #(.N(32), .STAGES(8)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2),
        .a(a2), .b(b2), .sub(s2), .out_valid(ov2), .out_ready(or2),
        .sum(sum2), .cout(co2), .ovf(of2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns {ovf, cout, sum} packed at bit n+1, n, n-1:0.
    function automatic logic [63:0] model(input int n, input logic [31:0] av,
                                          input logic [31:0] bv, input logic sv);
        logic [63:0] mask, aa, bb, full, r;
        logic        c, o;
        mask = (64'd1 << n) - 64'd1;
        aa   = {32'b0, av} & mask;
        bb   = (sv ? ~{32'b0, bv} : {32'b0, bv}) & mask;
        full = aa + bb + {63'b0, sv};
        r    = full & mask;
        c    = full[n];
        o    = (aa[n-1] == bb[n-1]) && (r[n-1] != aa[n-1]);
        return r | (64'(c) << n) | (64'(o) << (n + 1));
    endfunction

    task automatic op0(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic sv, input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        @(negedge clk);
        a0 = av; b0 = bv; s0 = sv; iv0 = 1'b1; or0 = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 64'(ir0), 64'd1);
        @(negedge clk);
        iv0 = 1'b0;
        lat = 1;
        while (!ov0 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd4);
        chk({tag, "_sum"}, 64'(sum0), 64'(es));
        chk({tag, "_cout_ovf"}, 64'({co0, of0}), 64'({ec, eo}));
    endtask

    initial begin
        int lat, cnt, sent, got, stall;
        int sent1, got1, sent2, got2;
        bit seen, p0, p1, p2;
        logic [15:0] held;
        logic [63:0] e;
        logic [63:0] q0[$];
        logic [63:0] q1[$];
        logic [63:0] q2[$];

        rst = 1'b1;
        iv0 = 0; a0 = '0; b0 = '0; s0 = 0; or0 = 1;
        iv1 = 0; a1 = '0; b1 = '0; s1 = 0; or1 = 1;
        iv2 = 0; a2 = '0; b2 = '0; s2 = 0; or2 = 1;
        repeat (2) @(negedge clk);
        chk("reset_out_valid", 64'(ov0), 64'd0);
        chk("reset_sum", 64'(sum0), 64'd0);
        chk("reset_cout_ovf", 64'({co0, of0}), 64'd0);
        chk("reset_in_ready", 64'(ir0), 64'd1);
        rst = 1'b0;

        op0("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
        op0("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        op0("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        op0("sub_0005_0007", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        op0("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        op0("sub_1234_1234", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

        // STAGES = 1: latency 1, 0xF0 + 0x20 = 0x10 with carry out
        @(negedge clk);
        a1 = 8'hF0; b1 = 8'h20; s1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        lat = 1;
        while (!ov1 && lat < 20) begin @(negedge clk); lat++; end
        chk("n8_latency", 64'(lat), 64'd1);
        chk("n8_result", 64'({of1, co1, sum1}), 64'({1'b0, 1'b1, 8'h10}));

        // STAGES = 8: latency 8, signed overflow across all chunks
        @(negedge clk);
        a2 = 32'h7FFF_FFFF; b2 = 32'h1; s2 = 1'b0; iv2 = 1'b1;
        @(negedge clk);
        iv2 = 1'b0;
        lat = 1;
        while (!ov2 && lat < 30) begin @(negedge clk); lat++; end
        chk("n32_latency", 64'(lat), 64'd8);
        chk("n32_result", 64'({of2, co2, sum2}), 64'({1'b1, 1'b0, 32'h8000_0000}));

        // back-to-back with a 3-cycle stall on the first result
        sent = 0; got = 0; stall = 0; seen = 0; p0 = 0; held = '0;
        for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
            @(negedge clk);
            if (ov0 && !seen) begin
                seen = 1; stall = 3; held = sum0;
            end
            or0 = (stall == 0);
            if (!p0 && sent < 8) begin
                a0 = 16'($urandom); b0 = 16'($urandom);
                s0 = 1'($urandom_range(0, 1)); p0 = 1;
            end
            iv0 = p0;
            #1;
            if (stall > 0) begin
                chk("stall_in_ready", 64'(ir0), 64'd0);
                chk("stall_sum_hold", 64'(sum0), 64'(held));
                stall--;
            end
            if (ov0 && or0) begin
                e = (q0.size() > 0) ? q0.pop_front() : '1;
                chk("b2b_result", 64'({of0, co0, sum0}), e);
                got++;
            end
            if (iv0 && ir0) begin
                q0.push_back(model(16, {16'b0, a0}, {16'b0, b0}, s0));
                sent++; p0 = 0;
            end
        end
        chk("b2b_count", 64'(got), 64'd8);
        chk("b2b_no_extra", 64'(q0.size()), 64'd0);

        // reset with the head result visible and three ops behind it
        @(negedge clk);
        iv0 = 1'b0; or0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a0 = 16'(16'h1111 * (i + 1)); b0 = 16'h0101; s0 = 1'b0; iv0 = 1'b1;
        end
        @(negedge clk);
        iv0 = 1'b0;
        chk("pre_rst_valid", 64'(ov0), 64'd1);
        chk("pre_rst_sum", 64'(sum0), 64'h1212);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(ov0), 64'd0);
        chk("mid_rst_sum", 64'(sum0), 64'd0);
        chk("mid_rst_flags", 64'({co0, of0}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (ov0) cnt++;
        end
        chk("post_rst_silent", 64'(cnt), 64'd0);

        // randomised traffic with random back-pressure on both small/large shapes
        sent1 = 0; got1 = 0; sent2 = 0; got2 = 0; p1 = 0; p2 = 0;
        for (int cyc = 0; cyc < 6000 && (got1 < 200 || got2 < 200); cyc++) begin
            @(negedge clk);
            or1 = ($urandom_range(0, 3) != 0);
            or2 = ($urandom_range(0, 3) != 0);
            if (!p1 && sent1 < 200 && $urandom_range(0, 3) != 0) begin
                a1 = 8'($urandom); b1 = 8'($urandom);
                s1 = 1'($urandom_range(0, 1)); p1 = 1;
            end
            if (!p2 && sent2 < 200 && $urandom_range(0, 3) != 0) begin
                a2 = $urandom; b2 = $urandom;
                s2 = 1'($urandom_range(0, 1)); p2 = 1;
            end
            iv1 = p1;
            iv2 = p2;
            #1;
            if (ov1 && or1) begin
                e = (q1.size() > 0) ? q1.pop_front() : '1;
                chk("rand_n8", 64'({of1, co1, sum1}), e);
                got1++;
            end
            if (ov2 && or2) begin
                e = (q2.size() > 0) ? q2.pop_front() : '1;
                chk("rand_n32", 64'({of2, co2, sum2}), e);
                got2++;
            end
            if (iv1 && ir1) begin
                q1.push_back(model(8, {24'b0, a1}, {24'b0, b1}, s1));
                sent1++; p1 = 0;
            end
            if (iv2 && ir2) begin
                q2.push_back(model(32, a2, b2, s2));
                sent2++; p2 = 0;
            end
        end
        chk("rand_n8_count", 64'(got1), 64'd200);
        chk("rand_n32_count", 64'(got2), 64'd200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
